// File: rtl/spi_responder_16.sv
// rtl/spi_responder_16.sv - 16-bit SPI responder with synchronized sclk/cs_bar/miso and short-frame detection
//
// Purpose: shifts one 16-bit word out on mosi and one 16-bit word in from miso per frame.
//          The remote end drives sclk and cs_bar, and it drives miso on the sclk falling edge, MSB first.
//          Every serial input is sampled into the clk domain before use.
// Ports:
//   clk        system clock, all registers on its rising edge
//   reset      synchronous, active-high reset
//   sclk       serial clock from the remote end (asynchronous)
//   cs_bar     active-low frame select from the remote end (asynchronous)
//   miso       serial data from the remote end (asynchronous)
//   tx_data    word to transmit; captured into the holding register by tx_load
//   tx_load    one-cycle load strobe for the holding register
//   loopback   (only with SPI_RESPONDER_LOOPBACK_EN) transmit the last received word instead
//   mosi       serial data to the remote end, MSB first, 0 outside SHIFT
//   rx_data    last complete received word
//   rx_valid   one-cycle pulse when rx_data updates
//   tx_done    one-cycle pulse when a 16-bit frame completes
//   busy       high while shifting
//   frame_err  one-cycle pulse when cs_bar rises before 16 bits
// Configuration macro: SPI_RESPONDER_LOOPBACK_EN adds the loopback input.

module spi_responder_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_bar,
    input  logic        miso,
    input  logic [15:0] tx_data,
    input  logic        tx_load,
`ifdef SPI_RESPONDER_LOOPBACK_EN
    input  logic        loopback,
`endif
    output logic        mosi,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        tx_done,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMPLETE} state_t;

    state_t      state;
    state_t      state_next;

    logic        sclk_s1, sclk_s2, sclk_h;
    logic        cs_s1, cs_s2, cs_h;
    logic        miso_s1, miso_s2, miso_h;
    logic [1:0]  sync_fill;
    logic        armed;
    logic [15:0] hold_reg;
    logic [15:0] tx_shift;
    logic [15:0] rx_shift;
    logic [4:0]  bit_cnt;
    logic [15:0] start_word;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, start, last_bit;

    assign sclk_rise = sclk_s2 & ~sclk_h;
    assign sclk_fall = ~sclk_s2 & sclk_h;
    assign cs_fall   = ~cs_s2 & cs_h;
    assign cs_rise   = cs_s2 & ~cs_h;

    // After reset the synchronizers hold cs_bar=1. That value is not real, so a low cs_bar
    // held across reset would look like a falling edge. armed is set only when a genuine
    // high has propagated through the whole chain.
    assign start     = (state == IDLE) && cs_fall && armed;
    assign last_bit  = sclk_rise && (bit_cnt == 5'd15);

    // miso_h lags sclk_s2 by one flop. When a rise is detected, miso_h holds the data
    // that was present just before the real sclk rising edge.
    always_comb begin
        start_word = tx_load ? tx_data : hold_reg;
`ifdef SPI_RESPONDER_LOOPBACK_EN
        if (loopback) start_word = rx_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = SHIFT;
            SHIFT: begin
                if (cs_rise)       state_next = IDLE;
                else if (last_bit) state_next = COMPLETE;
            end
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_h    <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_h      <= 1'b1;
            miso_s1   <= 1'b0;
            miso_s2   <= 1'b0;
            miso_h    <= 1'b0;
            sync_fill <= 2'd0;
            armed     <= 1'b0;
            hold_reg  <= 16'h0000;
            tx_shift  <= 16'h0000;
            rx_shift  <= 16'h0000;
            bit_cnt   <= 5'd0;
            rx_data   <= 16'h0000;
            frame_err <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            cs_s1   <= cs_bar;
            cs_s2   <= cs_s1;
            cs_h    <= cs_s2;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
            miso_h  <= miso_s2;

            if (sync_fill != 2'd3) sync_fill <= sync_fill + 2'd1;
            if ((sync_fill == 2'd3) && cs_s2 && cs_h) armed <= 1'b1;

            if (tx_load) hold_reg <= tx_data;

            frame_err <= (state == SHIFT) && cs_rise;

            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift <= start_word;
                        rx_shift <= 16'h0000;
                        bit_cnt  <= 5'd0;
                    end
                end
                SHIFT: begin
                    if (!cs_rise) begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[14:0], miso_h};
                            bit_cnt  <= bit_cnt + 5'd1;
                            // rx_data is loaded on entry to COMPLETE, so it is already valid
                            // while rx_valid is high.
                            if (last_bit) rx_data <= {rx_shift[14:0], miso_h};
                        end
                        // No shift on a falling edge that comes before the first rising edge.
                        // This keeps bit 15 on mosi until the remote end has sampled it.
                        if (sclk_fall && (bit_cnt != 5'd0))
                            tx_shift <= {tx_shift[14:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign mosi     = (state == SHIFT) & tx_shift[15];
    assign busy     = (state == SHIFT);
    assign rx_valid = (state == COMPLETE);
    assign tx_done  = (state == COMPLETE);

endmodule

// File: doc/spi_responder_16.md
SPI_RESPONDER_16 -- requirements
Module: spi_responder_16

Interface
REQ-001 SHALL have port clk  input  1  system clock; every register clocks on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port sclk  input  1  serial clock from the remote SPI end, asynchronous to clk.
REQ-004 SHALL have port cs_bar  input  1  active-low frame select from the remote end, asynchronous.
REQ-005 SHALL have port miso  input  1  serial data from the remote end (driven on sclk falling edge, MSB first), asynchronous.
REQ-006 SHALL have port tx_data  input  16  word to transmit.
REQ-007 SHALL have port tx_load  input  1  one-cycle strobe capturing tx_data into the holding register.
REQ-008 SHALL have port mosi  output  1  serial data to the remote end, MSB first.
REQ-009 SHALL have port rx_data  output  16  last complete received word.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse when a 16-bit frame completes.
REQ-012 SHALL have port busy  output  1  high while the FSM is in SHIFT.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a short frame.

Function
REQ-014 SHALL pass sclk, cs_bar and miso each through a two-flop synchronizer plus one history flop; edges are detected on the synchronized signals only.
REQ-015 SHALL operate correctly for sclk high and low times of at least 3 clk cycles each.
REQ-016 SHALL implement FSM states IDLE, SHIFT, COMPLETE; reset state IDLE.
REQ-017 IDLE -> SHIFT on a detected cs_bar falling edge; shift register loads from the holding register, bit counter clears, mosi presents bit 15 on the next cycle.
REQ-018 In SHIFT, each detected sclk rising edge SHALL shift synchronized miso into rx shift register LSB and increment the 5-bit bit counter.
REQ-019 In SHIFT, each detected sclk falling edge SHALL advance mosi to the next lower bit only if the bit counter is nonzero; a falling edge before the first rising edge does not shift.
REQ-020 SHIFT -> COMPLETE on the cycle the 16th rising edge is processed; COMPLETE lasts exactly one cycle, then IDLE.
REQ-021 In COMPLETE, rx_data SHALL load the shift register contents and rx_valid and tx_done SHALL pulse high for that one cycle.
REQ-022 Sclk edges after the 16th, until cs_bar rises, SHALL be ignored; mosi SHALL be 0 outside SHIFT.
REQ-023 A new frame SHALL start only from IDLE after cs_bar has been seen high then falling again.
REQ-024 cs_bar rising in SHIFT with fewer than 16 bits SHALL abort to IDLE, pulse frame_err one cycle, leave rx_data unchanged, no rx_valid/tx_done.
REQ-025 tx_load SHALL update the holding register in any state; a load during SHIFT affects the next frame only; without any load the last held word (0x0000 after reset) is resent.
REQ-026 Simultaneous cs_bar falling edge and tx_load SHALL transmit the newly loaded tx_data.
REQ-027 rx_data SHALL hold its value between COMPLETE cycles.

Reset
REQ-028 On reset high at any clk edge, including mid-frame: FSM IDLE, counter 0, shift registers 0, holding register 0x0000, synchronizers to cs_bar=1/sclk=0/miso=0, mosi=0, rx_data=0x0000, rx_valid=0, tx_done=0, busy=0, frame_err=0.
REQ-029 A frame in progress at reset SHALL be discarded; the next frame requires a fresh cs_bar falling edge.

Configuration
REQ-030 Macro SPI_RESPONDER_LOOPBACK_EN, when defined, SHALL add input port loopback (1 bit); with loopback=1, each frame start loads the transmit shift register from rx_data instead of the holding register.
REQ-031 Without SPI_RESPONDER_LOOPBACK_EN, the loopback port SHALL not exist and frames always transmit the holding register.

Verification
REQ-032 tx_load with 0x55AA, remote sends 0xA55A over 16 sclk cycles (half-period 5 clk) -> remote captures 0x55AA on mosi, rx_data=0xA55A, rx_valid and tx_done one cycle each.
REQ-033 cs_bar released after 9 rising edges -> frame_err one pulse, rx_data unchanged, busy low, no rx_valid.
REQ-034 tx_load 0x1234 mid-frame of a 0xABCD frame -> current frame sends 0xABCD, next frame sends 0x1234; no load before third frame -> 0x1234 again.
REQ-035 reset asserted after 8 bits, released, full frame 0x5678 -> rx_data=0x5678, all outputs 0 during reset.
REQ-036 With SPI_RESPONDER_LOOPBACK_EN, loopback=1, frame receives 0xBEEF -> following frame transmits 0xBEEF on mosi.
REQ-037 20 sclk rising edges in one frame carrying 0xC3C3 -> single rx_valid, rx_data=0xC3C3, extra edges ignored, mosi=0 after COMPLETE.
